muldiv_sequencer: RTL

//   Iterative multiply/divide unit with its own controller, sitting beside the EX-stage ALU.

---
 rtl/muldiv_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// The unit takes one operation at a time through the states IDLE -> RUN -> FIX -> IDLE.
// It works on operand magnitudes and restores the signs in FIX.
// The unit holds back the ID stage with stall while a dependent instruction waits.
// A branch flush drops an in-flight operation without touching HI/LO.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            hilo_read,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Iteration counter; counts the shift steps that have already been taken in RUN.
    logic [CNT_W-1:0] count_q;

    // Shared work registers. For a multiply, acc_q holds the high half of the running
    // product and mq_q holds the multiplier, which shifts out as product bits shift in.
    // For a divide, acc_q holds the partial remainder and mq_q holds the dividend,
    // which shifts out as quotient bits shift in.
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] mq_q;
    logic [XLEN-1:0] opb_q;      // |rt|: multiplicand or divisor magnitude

    logic is_div_q;              // operation is DIV/DIVU
    logic neg_res_q;             // signed op with differing operand signs
    logic neg_rem_q;             // signed divide with a negative dividend
    logic dz_q;                  // divide with a zero divisor

    // Decode of the incoming instruction.
    logic            op_signed;
    logic            op_div;
    logic            rs_neg;
    logic            rt_neg;
    logic [XLEN-1:0] rs_abs;
    logic [XLEN-1:0] rt_abs;
    logic            accept;
    logic            last_step;
    logic            commit;

    // One step of the iteration.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;
    logic [XLEN-1:0] acc_step;
    logic [XLEN-1:0] mq_step;

    // Sign fix-up of the finished magnitudes.
    logic [2*XLEN-1:0] prod_raw;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   hi_fix;
    logic [XLEN-1:0]   lo_fix;

    assign op_signed = ~op[0];
    assign op_div    = op[1];
    assign rs_neg    = op_signed & rs_val[XLEN-1];
    assign rt_neg    = op_signed & rt_val[XLEN-1];
    assign rs_abs    = rs_neg ? (~rs_val + 1'b1) : rs_val;
    assign rt_abs    = rt_neg ? (~rt_val + 1'b1) : rt_val;

    assign busy      = (state_q != IDLE);
    assign accept    = (state_q == IDLE) & start & ~flush;
    assign last_step = (count_q == CNT_W'(XLEN - 1));
    assign commit    = (state_q == FIX) & ~flush;

    // Hold ID back while an operation is in flight and the ID instruction needs HI/LO
    // or wants to start another operation.
    assign stall = busy & (start | hilo_read);

    // Single-step datapath: a shift-add for a multiply, a restoring shift-subtract for a divide.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mul_sum   = '0;
        div_shift = '0;
        div_ge    = 1'b0;
        div_diff  = '0;
        acc_step  = acc_q;
        mq_step   = mq_q;

        if (is_div_q) begin
            div_shift = {acc_q, mq_q[XLEN-1]};
            div_ge    = (div_shift >= {1'b0, opb_q});
            // The remainder stays below the divisor, so the difference fits in XLEN bits.
            div_diff  = div_shift[XLEN-1:0] - opb_q;
            acc_step  = div_ge ? div_diff : div_shift[XLEN-1:0];
            mq_step   = {mq_q[XLEN-2:0], div_ge};
        end else begin
            mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
            acc_step = mul_sum[XLEN:1];
            mq_step  = {mul_sum[0], mq_q[XLEN-1:1]};
        end
    end

    // Apply the signs to the finished magnitudes and choose the values written to HI/LO.
    always_comb begin
        prod_raw = {acc_q, mq_q};
        prod_fix = neg_res_q ? (~prod_raw + 1'b1) : prod_raw;
        // With a zero divisor the restoring loop produces an all-ones quotient and leaves
        // the dividend magnitude as the remainder. The quotient must then stay all ones
        // whatever the signs are.
        quot_fix = dz_q ? {XLEN{1'b1}} : (neg_res_q ? (~mq_q + 1'b1) : mq_q);
        rem_fix  = neg_rem_q ? (~acc_q + 1'b1) : acc_q;
        hi_fix   = prod_fix[2*XLEN-1:XLEN];
        lo_fix   = prod_fix[XLEN-1:0];
        if (is_div_q) begin
            hi_fix = rem_fix;
            lo_fix = quot_fix;
        end
    end

    // Controller next-state: accept in IDLE, iterate XLEN steps, fix up, and abort on flush.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (last_step) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignments. Then every register
        // samples values from before the edge, whatever order the blocks run in.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Work registers: load the magnitudes on accept, then take one step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the work registers are reset too. A reset then leaves no stale operand or
        // partial result behind, because every flop starts from a known value.
        if (!rst_n) begin
            count_q   <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else if (accept) begin
            count_q   <= '0;
            acc_q     <= '0;
            mq_q      <= rs_abs;
            opb_q     <= rt_abs;
            is_div_q  <= op_div;
            neg_res_q <= rs_neg ^ rt_neg;
            neg_rem_q <= op_div & rs_neg;
            dz_q      <= op_div & (rt_val == '0);
        end else if (state_q == RUN) begin
            count_q <= count_q + 1'b1;
            acc_q   <= acc_step;
            mq_q    <= mq_step;
        end
    end

    // Architectural HI/LO and the completion pulses. These are written only when FIX
    // completes without a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= commit;
            div_by_zero <= commit & dz_q;
            if (commit) begin
                hi <= hi_fix;
                lo <= lo_fix;
            end
        end
    end

endmodule
